// File: rtl/freq_key_if.sv
// Front-panel key and display bus for the frequency key controller.
interface freq_key_if;
    localparam int unsigned FREQ_W = 7;

    logic              key_up_n;
    logic              key_dn_n;
    logic              frame_start;
    logic [FREQ_W-1:0] freq_cfg;
    logic [FREQ_W-1:0] freq_num;
    logic              freq_chg;

    // Panel/LCD side: drives keys and frame timing, observes the setting.
    modport master (
        output key_up_n,
        output key_dn_n,
        output frame_start,
        input  freq_cfg,
        input  freq_num,
        input  freq_chg
    );

    // Controller side.
    modport slave (
        input  key_up_n,
        input  key_dn_n,
        input  frame_start,
        output freq_cfg,
        output freq_num,
        output freq_chg
    );
endinterface

// File: rtl/freq_key_ctrl.sv
// Up/down key handler: debounce, hold-to-repeat, saturating frequency
// register and a frame-latched shadow copy for the text overlay.
module freq_key_ctrl #(
    parameter logic [19:0] DEB_CNT    = 20'd1_000_000,
    parameter logic [24:0] REPEAT_DLY = 25'd25_000_000,
    parameter logic [22:0] REPEAT_PER = 23'd5_000_000,
    parameter logic [6:0]  FREQ_MIN   = 7'd20,
    parameter logic [6:0]  FREQ_MAX   = 7'd50,
    parameter logic [6:0]  FREQ_INIT  = 7'd20
) (
    input  logic      sys_clk,
    input  logic      sys_rst_n,
    freq_key_if.slave bus
);

    localparam int unsigned CNT_W  = 25;
    localparam int unsigned FREQ_W = 7;

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CNT) - CNT_W'(1);
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DLY) - CNT_W'(1);
    localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(REPEAT_PER) - CNT_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DEB,
        ST_HOLD,
        ST_RPT,
        ST_REL,
        ST_LOCK
    } state_t;

    logic              up_meta_q, up_sync_q;
    logic              dn_meta_q, dn_sync_q;
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              dir_q, dir_d;
    logic [FREQ_W-1:0] freq_cfg_q, freq_cfg_d;
    logic [FREQ_W-1:0] freq_num_q, freq_num_d;
    logic              freq_chg_q, freq_chg_d;

    logic              up_s, dn_s;
    logic              key_on, key_other;
    logic              step;

    assign up_s      = ~up_sync_q;
    assign dn_s      = ~dn_sync_q;
    // dir_q = 1 means the up key owns the current press.
    assign key_on    = dir_q ? up_s : dn_s;
    assign key_other = dir_q ? dn_s : up_s;

    // Next-state logic for the key FSM, shared counter and frequency registers.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dir_d      = dir_q;
        step       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (up_s && dn_s) begin
                    state_d = ST_LOCK;
                    cnt_d   = '0;
                end else if (up_s || dn_s) begin
                    dir_d   = up_s;
                    state_d = ST_DEB;
                    cnt_d   = '0;
                end
            end
            ST_DEB: begin
                if (!key_on) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (key_other) begin
                    state_d = ST_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    step    = 1'b1;
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (!key_on) begin
                    state_d = ST_REL;
                    cnt_d   = '0;
                end else if (key_other) begin
                    state_d = ST_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == DLY_LAST) begin
                    step    = 1'b1;
                    state_d = ST_RPT;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            ST_RPT: begin
                if (!key_on) begin
                    state_d = ST_REL;
                    cnt_d   = '0;
                end else if (key_other) begin
                    state_d = ST_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == RPT_LAST) begin
                    step    = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            ST_REL, ST_LOCK: begin
                // Both keys must be quiet for a full debounce window.
                if (up_s || dn_s) begin
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        freq_cfg_d = freq_cfg_q;
        if (step) begin
            if (dir_q) begin
                freq_cfg_d = (freq_cfg_q == FREQ_MAX) ? freq_cfg_q : freq_cfg_q + FREQ_W'(1);
            end else begin
                freq_cfg_d = (freq_cfg_q == FREQ_MIN) ? freq_cfg_q : freq_cfg_q - FREQ_W'(1);
            end
        end
        freq_chg_d = (freq_cfg_d != freq_cfg_q);

        // Shadow takes the registered value, so a coinciding step shows next frame.
        freq_num_d = bus.frame_start ? freq_cfg_q : freq_num_q;
    end

    // All state: key synchronizers, FSM, counter and output registers.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            up_meta_q  <= 1'b1;
            up_sync_q  <= 1'b1;
            dn_meta_q  <= 1'b1;
            dn_sync_q  <= 1'b1;
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            dir_q      <= 1'b0;
            freq_cfg_q <= FREQ_INIT;
            freq_num_q <= FREQ_INIT;
            freq_chg_q <= 1'b0;
        end else begin
            up_meta_q  <= bus.key_up_n;
            up_sync_q  <= up_meta_q;
            dn_meta_q  <= bus.key_dn_n;
            dn_sync_q  <= dn_meta_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dir_q      <= dir_d;
            freq_cfg_q <= freq_cfg_d;
            freq_num_q <= freq_num_d;
            freq_chg_q <= freq_chg_d;
        end
    end

    assign bus.freq_cfg = freq_cfg_q;
    assign bus.freq_num = freq_num_q;
    assign bus.freq_chg = freq_chg_q;

endmodule

// File: tb/tb_freq_key_ctrl.sv
// Scoreboard bench for freq_key_ctrl with short debounce/repeat timing.
module tb_freq_key_ctrl;

    localparam logic [19:0] DEB  = 20'd4;
    localparam logic [24:0] RDLY = 25'd10;
    localparam logic [22:0] RPER = 23'd3;
    localparam logic [6:0]  FMIN = 7'd20;
    localparam logic [6:0]  FMAX = 7'd50;
    localparam logic [6:0]  FINI = 7'd20;

    typedef struct {
        int unsigned cyc;
        logic [6:0]  val;
    } exp_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    int unsigned cyc   = 0;
    int          errors = 0;
    int          checks = 0;
    exp_t        sb_q[$];
    logic [6:0]  model_f;
    logic [6:0]  prev_num = FINI;
    logic        fs_at_edge = 1'b0;

    freq_key_if bus();

    freq_key_ctrl #(
        .DEB_CNT    (DEB),
        .REPEAT_DLY (RDLY),
        .REPEAT_PER (RPER),
        .FREQ_MIN   (FMIN),
        .FREQ_MAX   (FMAX),
        .FREQ_INIT  (FINI)
    ) dut (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) fs_at_edge <= bus.frame_start;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Expected steps for a single-key press of l cycles starting at cycle f.
    task automatic push_steps(input int unsigned f, input int unsigned l, input bit up);
        int unsigned t;
        int unsigned k;
        logic [6:0]  nv;
        t = 32'(DEB) + 3;
        k = 0;
        while (t <= l + 2) begin
            if (up) nv = (model_f == FMAX) ? model_f : model_f + 7'd1;
            else    nv = (model_f == FMIN) ? model_f : model_f - 7'd1;
            if (nv != model_f) sb_q.push_back('{f + t, nv});
            model_f = nv;
            t = (k == 0) ? t + 32'(RDLY) : t + 32'(RPER);
            k++;
        end
    endtask

    task automatic press(input bit up, input bit dn, input int unsigned l);
        @(negedge clk);
        if (up ^ dn) push_steps(cyc, l, up);
        bus.key_up_n = ~up;
        bus.key_dn_n = ~dn;
        repeat (l) @(negedge clk);
        bus.key_up_n = 1'b1;
        bus.key_dn_n = 1'b1;
    endtask

    task automatic gap(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic frame_pulse();
        @(negedge clk);
        bus.frame_start = 1'b1;
        @(negedge clk);
        bus.frame_start = 1'b0;
    endtask

    // Monitor: every freq_chg pulse must match the next scoreboard entry.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.freq_chg) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL freq_chg_unexpected: got pulse with freq_cfg=%0d, required none (cycle %0d)",
                         bus.freq_cfg, cyc);
            end else begin
                e = sb_q.pop_front();
                check("chg_cycle", int'(cyc), int'(e.cyc));
                check("chg_value", int'(bus.freq_cfg), int'(e.val));
            end
        end
        if (rst_n && bus.freq_num != prev_num) check("num_needs_frame", int'(fs_at_edge), 1);
        prev_num = bus.freq_num;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int unsigned f;
        bus.key_up_n    = 1'b1;
        bus.key_dn_n    = 1'b1;
        bus.frame_start = 1'b0;
        model_f         = FINI;
        #2 rst_n = 1'b0;
        gap(3);
        check("rst_freq_cfg", int'(bus.freq_cfg), 20);
        check("rst_freq_num", int'(bus.freq_num), 20);
        check("rst_freq_chg", int'(bus.freq_chg), 0);
        rst_n = 1'b1;
        gap(100);
        check("idle_freq_cfg", int'(bus.freq_cfg), 20);
        frame_pulse();
        check("idle_freq_num", int'(bus.freq_num), 20);

        press(1, 0, 3);   gap(20); check("glitch_no_step", int'(bus.freq_cfg), 20);
        press(1, 0, 12);  gap(20); check("single_step", int'(bus.freq_cfg), 21);
        press(1, 0, 40);  gap(20); check("repeat_up", int'(bus.freq_cfg), 31);
        press(1, 0, 60);  gap(20); check("repeat_up_48", int'(bus.freq_cfg), 48);
        press(1, 0, 12);  gap(20); check("step_49", int'(bus.freq_cfg), 49);
        press(1, 0, 40);  gap(20); check("sat_max", int'(bus.freq_cfg), 50);
        press(0, 1, 100); gap(20); check("repeat_down", int'(bus.freq_cfg), 20);
        press(0, 1, 40);  gap(20); check("sat_min", int'(bus.freq_cfg), 20);
        press(1, 1, 30);  gap(20); check("both_lock", int'(bus.freq_cfg), 20);
        press(1, 0, 12);  gap(20); check("after_lock", int'(bus.freq_cfg), 21);

        // Up, then down joins during HOLD: only the debounce step lands.
        @(negedge clk);
        f = cyc;
        sb_q.push_back('{f + 7, 7'd22});
        model_f = 7'd22;
        bus.key_up_n = 1'b0;
        gap(10);
        bus.key_dn_n = 1'b0;
        gap(20);
        bus.key_up_n = 1'b1;
        bus.key_dn_n = 1'b1;
        gap(20); check("hold_lock", int'(bus.freq_cfg), 22);
        press(1, 0, 12);  gap(20); check("after_lock2", int'(bus.freq_cfg), 23);
        press(1, 0, 30);  gap(20); check("reach_30", int'(bus.freq_cfg), 30);
        frame_pulse();
        check("num_30", int'(bus.freq_num), 30);

        // Step 30->31 on the same edge as frame_start.
        @(negedge clk);
        f = cyc;
        sb_q.push_back('{f + 7, 7'd31});
        model_f = 7'd31;
        bus.key_up_n = 1'b0;
        gap(6);
        bus.frame_start = 1'b1;
        gap(1);
        bus.frame_start = 1'b0;
        check("coincide_num_old", int'(bus.freq_num), 30);
        check("coincide_cfg_new", int'(bus.freq_cfg), 31);
        gap(5);
        bus.key_up_n = 1'b1;
        gap(10);
        check("num_held", int'(bus.freq_num), 30);
        frame_pulse();
        check("num_next_frame", int'(bus.freq_num), 31);

        // Reset mid-press with the key still held across release.
        @(negedge clk);
        bus.key_up_n = 1'b0;
        gap(4);
        rst_n = 1'b0;
        #1;
        check("midrst_freq_cfg", int'(bus.freq_cfg), 20);
        check("midrst_freq_num", int'(bus.freq_num), 20);
        check("midrst_freq_chg", int'(bus.freq_chg), 0);
        gap(3);
        f = cyc;
        sb_q.push_back('{f + 7, 7'd21});
        model_f = 7'd21;
        rst_n = 1'b1;
        gap(12);
        bus.key_up_n = 1'b1;
        gap(20);
        check("post_rst_step", int'(bus.freq_cfg), 21);

        check("sb_drained", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
